// File: rtl/booth_divide_if.sv
// Start/busy/done handshake and operand/result bundle for the booth_divide sequential divider.
// The master drives the request and operands; the slave returns the status and results.
interface booth_divide_if #(
    parameter int M_bits = 12,
    parameter int N_bits = 8
);
    logic                       start;
    logic [M_bits+N_bits-1:0]   dvd;
    logic [M_bits-1:0]          dvs;
    logic                       busy;
    logic                       done;
    logic [N_bits-1:0]          quo;
    logic [M_bits-1:0]          rem;
    logic                       div_by_zero;
    logic                       overflow;

    modport master (
        output start, dvd, dvs,
        input  busy, done, quo, rem, div_by_zero, overflow
    );

    modport slave (
        input  start, dvd, dvs,
        output busy, done, quo, rem, div_by_zero, overflow
    );
endinterface

// File: rtl/booth_divide.sv
// Sequential signed restoring divider: recovers the N_bits multiplier from an
// (M_bits+N_bits) product and the M_bits multiplicand, with saturation and divide-by-zero flags.
module booth_divide #(
    parameter int M_bits = 12,
    parameter int N_bits = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    booth_divide_if.slave bus
);
    localparam int            W       = M_bits + N_bits;
    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  NEG_LIM = W'(1) << (N_bits - 1);
    localparam logic [W-1:0]  POS_LIM = NEG_LIM - W'(1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                zero_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;
    logic                ovf_q;
    logic [N_bits-1:0]   quo_q;
    logic [M_bits-1:0]   rem_q;

    logic [W-1:0]        qsh;
    logic [M_bits:0]     pr;
    logic [M_bits-1:0]   dvs_mag;
    logic                sign_q;
    logic                sign_r;

    logic signed [W-1:0]      dvd_s;
    logic signed [M_bits-1:0] dvs_s;
    logic [W-1:0]             dvd_abs;
    logic [M_bits-1:0]        dvs_abs;
    logic [M_bits:0]          trial;
    logic [M_bits:0]          diff;
    logic                     fits;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(width-1).
    assign dvd_s   = bus.dvd;
    assign dvs_s   = bus.dvs;
    assign dvd_abs = dvd_s[W-1] ? $unsigned(-dvd_s) : $unsigned(dvd_s);
    assign dvs_abs = dvs_s[M_bits-1] ? $unsigned(-dvs_s) : $unsigned(dvs_s);

    assign trial = {pr[M_bits-1:0], qsh[W-1]};
    assign fits  = trial >= {1'b0, dvs_mag};
    assign diff  = trial - {1'b0, dvs_mag};

    // Returns {overflow, quotient}; saturates to the signed N_bits limits.
    function automatic logic [N_bits:0] sat_quo(input logic [W-1:0] mag, input logic neg);
        logic [N_bits-1:0] lo;
        lo = mag[N_bits-1:0];
        if (neg) begin
            if (mag > NEG_LIM) return {1'b1, 1'b1, {(N_bits-1){1'b0}}};
            return {1'b0, -lo};
        end
        if (mag > POS_LIM) return {1'b1, 1'b0, {(N_bits-1){1'b1}}};
        return {1'b0, lo};
    endfunction

    function automatic logic [M_bits-1:0] apply_sign(input logic [M_bits-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        ovf_q  <= 1'b0;
                        cnt    <= '0;
                        zero_q <= (bus.dvs == '0);
                        state  <= (bus.dvs == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (zero_q) begin
                        dbz_q <= 1'b1;
                        quo_q <= '0;
                        rem_q <= '0;
                    end else begin
                        {ovf_q, quo_q} <= sat_quo(qsh, sign_q);
                        rem_q          <= apply_sign(pr[M_bits-1:0], sign_r);
                    end
                    state <= DONE;
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: dividend shifts out MSB-first while quotient bits shift in at the LSB.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            qsh     <= dvd_abs;
            pr      <= '0;
            dvs_mag <= dvs_abs;
            sign_q  <= dvd_s[W-1] ^ dvs_s[M_bits-1];
            sign_r  <= dvd_s[W-1];
        end else if (state == ITER) begin
            qsh <= {qsh[W-2:0], fits};
            pr  <= fits ? diff : trial;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quo         = quo_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_booth_divide.sv
// Self-checking bench for booth_divide: directed cases, handshake corner cases and a
// randomized loop compared against plain-arithmetic signed division and a Booth product.
module tb_booth_divide;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    booth_divide_if #(.M_bits(12), .N_bits(8)) bus ();

    booth_divide #(.M_bits(12), .N_bits(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [19:0] d_dvd [6] = '{20'h01000, 20'd100, 20'hFFF9C, 20'd100, 20'h7FFFF, 20'hFFF80};
    logic [11:0] d_dvs [6] = '{12'hF00, 12'd7, 12'd7, 12'hFF9, 12'h001, 12'h001};
    logic [7:0]  d_quo [6] = '{8'hF0, 8'h0E, 8'hF2, 8'hF2, 8'h7F, 8'h80};
    logic [11:0] d_rem [6] = '{12'h000, 12'h002, 12'hFFE, 12'h002, 12'h000, 12'h000};
    logic        d_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reference: signed division truncating toward zero, remainder follows the dividend.
    function automatic void model(input logic [19:0] a, input logic [11:0] b,
                                  output logic [7:0] q, output logic [11:0] r,
                                  output logic ov, output logic dz);
        int sa, sb, qi, ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '0; r = '0; ov = 1'b0; dz = 1'b1;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            dz = 1'b0;
            ov = (qi > 127) || (qi < -128);
            q  = ov ? ((qi > 0) ? 8'h7F : 8'h80) : qi[7:0];
            r  = ri[11:0];
        end
    endfunction

    // Radix-4 Booth product of a signed multiplicand and an 8-bit signed multiplier.
    function automatic int booth_mul(input int m, input logic [7:0] r);
        logic [8:0] rr;
        int acc, d;
        rr  = {r, 1'b0};
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            d   = -2 * int'(rr[2*i+2]) + int'(rr[2*i+1]) + int'(rr[2*i]);
            acc = acc + d * m * (1 << (2 * i));
        end
        return acc;
    endfunction

    task automatic do_op(input logic [19:0] a, input logic [11:0] b, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = a;
        bus.dvs   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quo, bus.rem} !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b dbz=%b quo=%h rem=%h, want all 0",
                     bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quo, bus.rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            do_op(d_dvd[i], d_dvs[i], lat, bcnt);
            checks++;
            if (lat !== 22) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d, want 22", i, lat);
            end
            checks++;
            if (bcnt !== 22) begin
                errors++;
                $display("FAIL dir%0d_busy_cycles: got %0d, want 22", i, bcnt);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_busy_at_done: got %b, want 0", i, bus.busy);
            end
            checks++;
            if (bus.quo !== d_quo[i]) begin
                errors++;
                $display("FAIL dir%0d_quo: got %h, want %h", i, bus.quo, d_quo[i]);
            end
            if (d_ovf[i] == 1'b0) begin
                checks++;
                if (bus.rem !== d_rem[i]) begin
                    errors++;
                    $display("FAIL dir%0d_rem: got %h, want %h", i, bus.rem, d_rem[i]);
                end
            end
            checks++;
            if ({bus.overflow, bus.div_by_zero} !== {d_ovf[i], 1'b0}) begin
                errors++;
                $display("FAIL dir%0d_flags: got ovf=%b dbz=%b, want ovf=%b dbz=0",
                         i, bus.overflow, bus.div_by_zero, d_ovf[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.quo !== d_quo[i]) begin
                errors++;
                $display("FAIL dir%0d_done_strobe_hold: got done=%b quo=%h, want done=0 quo=%h",
                         i, bus.done, bus.quo, d_quo[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        do_op(20'h12345, 12'h000, lat, bcnt);
        checks++;
        if (lat !== 2 || bcnt !== 2) begin
            errors++;
            $display("FAIL dbz_timing: got latency=%0d busy=%0d, want 2 and 2", lat, bcnt);
        end
        checks++;
        if ({bus.div_by_zero, bus.overflow, bus.quo, bus.rem} !== {1'b1, 1'b0, 8'h00, 12'h000}) begin
            errors++;
            $display("FAIL dbz_result: got dbz=%b ovf=%b quo=%h rem=%h, want 1 0 00 000",
                     bus.div_by_zero, bus.overflow, bus.quo, bus.rem);
        end
        do_op(20'd50, 12'd5, lat, bcnt);
        checks++;
        if ({bus.div_by_zero, bus.quo, bus.rem} !== {1'b0, 8'h0A, 12'h000}) begin
            errors++;
            $display("FAIL dbz_clear: got dbz=%b quo=%h rem=%h, want 0 0a 000",
                     bus.div_by_zero, bus.quo, bus.rem);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = 20'd100;
        bus.dvs   = 12'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b1;
        bus.dvd   = 20'h7FFFF;
        bus.dvs   = 12'h001;
        @(posedge clk);
        #1;
        lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 22) begin
            errors++;
            $display("FAIL ignore_latency: got %0d, want 22", lat);
        end
        checks++;
        if ({bus.quo, bus.rem, bus.overflow} !== {8'h0E, 12'h002, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result: got quo=%h rem=%h ovf=%b, want 0e 002 0",
                     bus.quo, bus.rem, bus.overflow);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_queue: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = 20'h01000;
        bus.dvs   = 12'hF00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quo, bus.rem} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b ovf=%b dbz=%b quo=%h rem=%h, want all 0",
                     bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quo, bus.rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d active cycles, want 0", seen);
        end
        do_op(20'h01000, 12'hF00, lat, bcnt);
        checks++;
        if (lat !== 22 || bus.quo !== 8'hF0 || bus.rem !== 12'h000) begin
            errors++;
            $display("FAIL midreset_recover: got latency=%0d quo=%h rem=%h, want 22 f0 000",
                     lat, bus.quo, bus.rem);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dvd   = 20'h7FFFF;
        bus.dvs   = 12'h001;
        @(posedge clk);
        #1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 22 || bus.overflow !== 1'b1 || bus.quo !== 8'h7F) begin
            errors++;
            $display("FAIL b2b_first: got latency=%0d ovf=%b quo=%h, want 22 1 7f",
                     lat, bus.overflow, bus.quo);
        end
        bus.dvd = 20'hFFF9C;
        bus.dvs = 12'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b ovf=%b, want busy=1 ovf=0", bus.busy, bus.overflow);
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 22 || bus.quo !== 8'hF2 || bus.rem !== 12'hFFE) begin
            errors++;
            $display("FAIL b2b_second: got latency=%0d quo=%h rem=%h, want 22 f2 ffe",
                     lat, bus.quo, bus.rem);
        end
    endtask

    task automatic test_random;
        int lat, bcnt, sa, sb, qr, a0, rm, ai, qv, rv;
        logic [19:0] a;
        logic [11:0] b;
        logic [7:0]  eq;
        logic [11:0] er;
        logic        eov, edz;
        for (int n = 0; n < 1000; n++) begin
            b = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                b = 12'($urandom_range(1, 15));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            if (b == 12'h000) b = 12'h001;
            sb = int'($signed(b));
            if ($urandom_range(0, 1) == 1) begin
                a = 20'($urandom);
            end else begin
                qr = int'($urandom_range(0, 255)) - 128;
                a0 = qr * sb;
                rm = int'($urandom_range(0, ((sb < 0) ? -sb : sb) - 1));
                ai = (a0 < 0) ? a0 - rm : a0 + rm;
                a  = 20'(ai);
            end
            sa = int'($signed(a));
            model(a, b, eq, er, eov, edz);
            do_op(a, b, lat, bcnt);
            checks++;
            if (lat !== 22) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d, want 22", n, lat);
            end
            checks++;
            if ({bus.quo, bus.overflow, bus.div_by_zero} !== {eq, eov, edz}) begin
                errors++;
                $display("FAIL rnd%0d_quo: dvd=%h dvs=%h got quo=%h ovf=%b dbz=%b, want %h %b %b",
                         n, a, b, bus.quo, bus.overflow, bus.div_by_zero, eq, eov, edz);
            end
            checks++;
            if (bus.rem !== er) begin
                errors++;
                $display("FAIL rnd%0d_rem: dvd=%h dvs=%h got %h, want %h", n, a, b, bus.rem, er);
            end
            if (bus.overflow === 1'b0) begin
                qv = int'($signed(bus.quo));
                rv = int'($signed(bus.rem));
                checks++;
                if (qv * sb + rv !== sa || booth_mul(sb, bus.quo) !== sa - rv) begin
                    errors++;
                    $display("FAIL rnd%0d_roundtrip: dvd=%0d got quo*dvs+rem=%0d booth=%0d, want %0d",
                             n, sa, qv * sb + rv, booth_mul(sb, bus.quo), sa - rv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
